// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode encodings, sequencer FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_pkg;

    // Default operand/result width; also the width of the byte front-end.
    localparam int SIZEDATA_DEF = 8;
    // Default opcode width; must not exceed the operand width.
    localparam int SIZEOP_DEF   = 6;

    // Opcode encodings understood by the ALU (function-field style).
    localparam logic [SIZEOP_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [SIZEOP_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [SIZEOP_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [SIZEOP_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [SIZEOP_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [SIZEOP_DEF-1:0] OP_NOR = 6'b100111;
    localparam logic [SIZEOP_DEF-1:0] OP_SRL = 6'b000010;
    localparam logic [SIZEOP_DEF-1:0] OP_SRA = 6'b000011;

    // Sequencer states: three byte-collection states, one ALU settle cycle, result hand-off.
    typedef enum logic [2:0] {
        ST_GET_A  = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SEND   = 3'd4
    } seq_state_t;

    // True in the states that accept input bytes.
    function automatic logic is_rx_state(input seq_state_t st);
        return (st == ST_GET_A) || (st == ST_GET_B) || (st == ST_GET_OP);
    endfunction

endpackage

// File: rtl/alu_operand_sequencer.sv
// Collects A, B, OPCODE bytes, drives the ALU with registered operands, returns RESULT/CARRY.
// Latency: opcode byte accepted on edge t -> TX_VALID high after edge t+1 (one EXEC cycle).
// Backpressure: RX_READY low during EXEC/SEND; result held stable until TX_VALID & TX_READY.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int SIZEDATA = SIZEDATA_DEF,
    parameter int SIZEOP   = SIZEOP_DEF
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic [SIZEDATA-1:0] RX_DATA,
    input  logic                RX_VALID,
    output logic                RX_READY,
    output logic [SIZEDATA-1:0] ALU_DATOA,
    output logic [SIZEDATA-1:0] ALU_DATOB,
    output logic [SIZEOP-1:0]   ALU_OPCODE,
    input  logic [SIZEDATA-1:0] ALU_RESULT,
    input  logic                ALU_CARRY,
    output logic [SIZEDATA-1:0] TX_DATA,
    output logic                TX_CARRY,
    output logic                TX_VALID,
    input  logic                TX_READY
);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;

    logic [SIZEDATA-1:0] r_datoa;
    logic [SIZEDATA-1:0] r_datob;
    logic [SIZEOP-1:0]   r_opcode;
    logic [SIZEDATA-1:0] r_tx_data;
    logic                r_tx_carry;
    logic                r_tx_vld;

    logic                w_rx_rdy;
    logic                w_rx_xfer;
    logic                w_ld_a;
    logic                w_ld_b;
    logic                w_ld_op;
    logic                w_capture;
    logic                w_tx_done;

    // A byte moves only when both sides agree; ready already carries the reset gating.
    assign w_rx_xfer = RX_VALID & w_rx_rdy;

    // State register: reset parks the sequencer waiting for operand A.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_GET_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: byte states advance on a transfer, EXEC is a single settle cycle,
    // SEND waits for the consumer to take the result.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_GET_A:  if (w_rx_xfer) w_state_nxt = ST_GET_B;
            ST_GET_B:  if (w_rx_xfer) w_state_nxt = ST_GET_OP;
            ST_GET_OP: if (w_rx_xfer) w_state_nxt = ST_EXEC;
            ST_EXEC:   w_state_nxt = ST_SEND;
            ST_SEND:   if (r_tx_vld && TX_READY) w_state_nxt = ST_GET_A;
            default:   w_state_nxt = ST_GET_A;
        endcase
    end

    // Output/strobe decode: ready is forced low while reset is held so nothing is
    // offered to the front-end before the sequencer is running.
    always_comb begin
        w_rx_rdy  = RSTN & is_rx_state(r_state);
        w_ld_a    = 1'b0;
        w_ld_b    = 1'b0;
        w_ld_op   = 1'b0;
        w_capture = 1'b0;
        w_tx_done = 1'b0;
        case (r_state)
            ST_GET_A:  w_ld_a    = RX_VALID & w_rx_rdy;
            ST_GET_B:  w_ld_b    = RX_VALID & w_rx_rdy;
            ST_GET_OP: w_ld_op   = RX_VALID & w_rx_rdy;
            ST_EXEC:   w_capture = 1'b1;
            ST_SEND:   w_tx_done = r_tx_vld & TX_READY;
            default:   ;
        endcase
    end

    // Operand registers: each loads only on its own byte and otherwise holds, so the
    // ALU inputs stay at the last operation's values between operations.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_datoa  <= '0;
            r_datob  <= '0;
            r_opcode <= '0;
        end else begin
            if (w_ld_a)  r_datoa  <= RX_DATA;
            if (w_ld_b)  r_datob  <= RX_DATA;
            // Opcode takes the low bits of the byte; the upper bits are dropped.
            if (w_ld_op) r_opcode <= RX_DATA[SIZEOP-1:0];
        end
    end

    // Result registers: sample the ALU at the end of EXEC (operands have been stable a
    // full cycle) and keep data/carry after the hand-off; only valid drops.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_tx_data  <= '0;
            r_tx_carry <= 1'b0;
            r_tx_vld   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_tx_data  <= ALU_RESULT;
                r_tx_carry <= ALU_CARRY;
                r_tx_vld   <= 1'b1;
            end else if (w_tx_done) begin
                r_tx_vld   <= 1'b0;
            end
        end
    end

    assign RX_READY   = w_rx_rdy;
    assign ALU_DATOA  = r_datoa;
    assign ALU_DATOB  = r_datob;
    assign ALU_OPCODE = r_opcode;
    assign TX_DATA    = r_tx_data;
    assign TX_CARRY   = r_tx_carry;
    assign TX_VALID   = r_tx_vld;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural ALU beside it.
// Latency: checks the one-cycle EXEC gap between opcode acceptance and TX_VALID.
// Backpressure: exercises TX_READY stalls with stray RX bytes offered during SEND.
module tb_alu_operand_sequencer;
    import alu_pkg::*;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;
    logic [7:0] ALU_DATOA;
    logic [7:0] ALU_DATOB;
    logic [5:0] ALU_OPCODE;
    logic [7:0] ALU_RESULT;
    logic       ALU_CARRY;
    logic [7:0] TX_DATA;
    logic       TX_CARRY;
    logic       TX_VALID;
    logic       TX_READY;

    typedef struct packed {
        logic [7:0] d;
        logic       c;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_operand_sequencer #(.SIZEDATA(8), .SIZEOP(6)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .RX_DATA    (RX_DATA),
        .RX_VALID   (RX_VALID),
        .RX_READY   (RX_READY),
        .ALU_DATOA  (ALU_DATOA),
        .ALU_DATOB  (ALU_DATOB),
        .ALU_OPCODE (ALU_OPCODE),
        .ALU_RESULT (ALU_RESULT),
        .ALU_CARRY  (ALU_CARRY),
        .TX_DATA    (TX_DATA),
        .TX_CARRY   (TX_CARRY),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY)
    );

    always #5 CLK = ~CLK;

    // Behavioural ALU standing in for the neighbouring instance.
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide   = '0;
        ALU_RESULT = '0;
        ALU_CARRY  = 1'b0;
        case (ALU_OPCODE)
            OP_ADD: begin
                alu_wide   = {1'b0, ALU_DATOA} + {1'b0, ALU_DATOB};
                ALU_RESULT = alu_wide[7:0];
                ALU_CARRY  = alu_wide[8];
            end
            OP_SUB: begin
                alu_wide   = {1'b0, ALU_DATOA} - {1'b0, ALU_DATOB};
                ALU_RESULT = alu_wide[7:0];
                ALU_CARRY  = alu_wide[8];
            end
            OP_AND: ALU_RESULT = ALU_DATOA & ALU_DATOB;
            OP_OR:  ALU_RESULT = ALU_DATOA | ALU_DATOB;
            OP_XOR: ALU_RESULT = ALU_DATOA ^ ALU_DATOB;
            OP_NOR: ALU_RESULT = ~(ALU_DATOA | ALU_DATOB);
            OP_SRL: ALU_RESULT = ALU_DATOA >> ALU_DATOB;
            OP_SRA: ALU_RESULT = 8'($signed(ALU_DATOA) >>> ALU_DATOB);
            default: ALU_RESULT = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte after 'gap' idle cycles; returns at posedge+1 after the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        RX_VALID = 1'b0;
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
        RX_DATA  = b;
        RX_VALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (RX_READY === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rx_accept", {31'd0, ok}, 32'd1);
        @(posedge CLK);
        #1;
        RX_VALID = 1'b0;
    endtask

    // Pop the expected result and follow the EXEC/SEND/return sequence cycle by cycle.
    task automatic expect_tx(input logic [7:0] a, input logic [5:0] op, input int hold);
        exp_t e;
        e = sb_q.pop_front();
        @(negedge CLK);
        chk("exec_tx_valid", {31'd0, TX_VALID}, 32'd0);
        chk("exec_rx_ready", {31'd0, RX_READY}, 32'd0);
        chk("alu_opcode", {26'd0, ALU_OPCODE}, {26'd0, op});
        @(negedge CLK);
        chk("tx_valid", {31'd0, TX_VALID}, 32'd1);
        chk("tx_data", {24'd0, TX_DATA}, {24'd0, e.d});
        chk("tx_carry", {31'd0, TX_CARRY}, {31'd0, e.c});
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge CLK);
                chk("hold_tx_valid", {31'd0, TX_VALID}, 32'd1);
                chk("hold_tx_data", {24'd0, TX_DATA}, {24'd0, e.d});
                chk("hold_tx_carry", {31'd0, TX_CARRY}, {31'd0, e.c});
                chk("hold_rx_ready", {31'd0, RX_READY}, 32'd0);
            end
            @(posedge CLK);
            #1;
            TX_READY = 1'b1;
            RX_VALID = 1'b0;
        end
        @(posedge CLK);
        @(negedge CLK);
        chk("tx_valid_drop", {31'd0, TX_VALID}, 32'd0);
        chk("rx_ready_get_a", {31'd0, RX_READY}, 32'd1);
        chk("tx_data_kept", {24'd0, TX_DATA}, {24'd0, e.d});
        chk("alu_datoa_kept", {24'd0, ALU_DATOA}, {24'd0, a});
        @(posedge CLK);
        #1;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input int ga, input int gb, input int go,
                          input logic [7:0] exp_d, input logic exp_c,
                          input int hold, input logic stray);
        logic [5:0] op_lo;
        op_lo    = op[5:0];
        TX_READY = (hold == 0);
        send_byte(a, ga);
        send_byte(b, gb);
        sb_q.push_back('{d: exp_d, c: exp_c});
        send_byte(op, go);
        if (stray) begin
            RX_DATA  = 8'h77;
            RX_VALID = 1'b1;
        end
        expect_tx(a, op_lo, hold);
    endtask

    initial begin
        RSTN     = 1'b0;
        RX_DATA  = 8'h00;
        RX_VALID = 1'b0;
        TX_READY = 1'b1;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_rx_ready", {31'd0, RX_READY}, 32'd0);
        chk("rst_tx_valid", {31'd0, TX_VALID}, 32'd0);
        chk("rst_tx_data", {24'd0, TX_DATA}, 32'd0);
        chk("rst_alu_datoa", {24'd0, ALU_DATOA}, 32'd0);
        chk("rst_alu_opcode", {26'd0, ALU_OPCODE}, 32'd0);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        @(negedge CLK);
        chk("post_rst_rx_ready", {31'd0, RX_READY}, 32'd1);
        @(posedge CLK);
        #1;

        // 1: ADD 5+3
        run_op(8'h05, 8'h03, 8'h20, 0, 0, 0, 8'h08, 1'b0, 0, 1'b0);
        // 2: ADD with carry out
        run_op(8'hFF, 8'h01, 8'h20, 0, 0, 0, 8'h00, 1'b1, 0, 1'b0);
        // 3: opcode upper bits dropped -> AND
        run_op(8'hF0, 8'h3C, 8'hE4, 0, 0, 0, 8'h30, 1'b0, 0, 1'b0);
        // 4: TX stall for 6 cycles with stray RX bytes offered (SUB 10-4)
        run_op(8'h0A, 8'h04, 8'h22, 0, 0, 0, 8'h06, 1'b0, 6, 1'b1);
        // 5: RX_VALID gaps between bytes
        run_op(8'h05, 8'h03, 8'h20, 3, 1, 2, 8'h08, 1'b0, 0, 1'b0);
        run_op(8'h05, 8'h03, 8'h20, 0, 2, 3, 8'h08, 1'b0, 0, 1'b0);
        // XOR and SUB borrow as extra patterns
        run_op(8'h5A, 8'hFF, 8'h26, 1, 0, 0, 8'hA5, 1'b0, 0, 1'b0);
        run_op(8'h01, 8'h02, 8'h22, 0, 0, 1, 8'hFF, 1'b1, 0, 1'b0);

        // 6: reset in the middle of an operation
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        chk("pre_rst_alu_datob", {24'd0, ALU_DATOB}, 32'h22);
        #2;
        RSTN = 1'b0;
        #1;
        chk("midrst_alu_datoa", {24'd0, ALU_DATOA}, 32'd0);
        chk("midrst_alu_datob", {24'd0, ALU_DATOB}, 32'd0);
        chk("midrst_alu_opcode", {26'd0, ALU_OPCODE}, 32'd0);
        chk("midrst_tx_data", {24'd0, TX_DATA}, 32'd0);
        chk("midrst_tx_carry", {31'd0, TX_CARRY}, 32'd0);
        chk("midrst_tx_valid", {31'd0, TX_VALID}, 32'd0);
        chk("midrst_rx_ready", {31'd0, RX_READY}, 32'd0);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        run_op(8'h02, 8'h02, 8'h20, 0, 0, 0, 8'h04, 1'b0, 0, 1'b0);

        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
